// File: rtl/rr_arbiter_8_if.sv
// Request/grant bundle between a set of requesters and the round-robin
// arbiter. The arbiter owns the grant side (slave modport); whatever drives
// the request lines and the enable uses the master modport.
interface rr_arbiter_8_if #(
   parameter int N_REQ = 8,
   parameter int IDX_W = 3
);
   logic             en;
   logic [N_REQ-1:0] req;
   logic [N_REQ-1:0] gnt;
   logic [IDX_W-1:0] gnt_idx;
   logic             gnt_valid;

   // Requester side: drives enable and requests, observes the grant.
   modport master (
      output en,
      output req,
      input  gnt,
      input  gnt_idx,
      input  gnt_valid
   );

   // Arbiter side: samples enable and requests, drives the registered grant.
   modport slave (
      input  en,
      input  req,
      output gnt,
      output gnt_idx,
      output gnt_valid
   );
endinterface

// File: rtl/rr_arbiter_8.sv
// Eight-way round-robin arbiter with a bounded hold time.
// Grants are registered: a request sampled at one edge shows up on gnt one
// cycle later. The owner keeps the grant while it requests, but once it has
// held it MAX_HOLD cycles and somebody else is waiting it is preempted.
// A lone requester is never preempted; the hold counter saturates instead.
module rr_arbiter_8 #(
   parameter int N_REQ    = 8,
   parameter int IDX_W    = 3,
   parameter int MAX_HOLD = 4
) (
   input logic           clk,
   input logic           rst_n,
   rr_arbiter_8_if.slave bus
);

   localparam int HOLD_W = (MAX_HOLD < 1) ? 1 : $clog2(MAX_HOLD + 1);
   localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(MAX_HOLD);
   localparam logic [HOLD_W-1:0] HOLD_ONE = HOLD_W'(1);

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_GRANT = 1'b1
   } state_t;

   // Registered state and its next-state counterparts.
   state_t            state_q,     state_d;
   logic [IDX_W-1:0]  ptr_q,       ptr_d;
   logic [HOLD_W-1:0] hold_q,      hold_d;
   logic [N_REQ-1:0]  gnt_q,       gnt_d;
   logic [IDX_W-1:0]  gnt_idx_q,   gnt_idx_d;
   logic              gnt_valid_q, gnt_valid_d;

   // Search inputs and result.
   logic [IDX_W-1:0]  search_base;
   logic [N_REQ-1:0]  search_mask;
   logic [IDX_W-1:0]  win_idx;
   logic              win_found;

   // Decision strobes produced by the FSM.
   logic              grant_new;
   logic              go_idle;

   // Where the circular search starts and which requests take part.
   // While idle the search starts at the stored pointer; while granted it
   // starts just past the owner and skips the owner itself, so a hit means
   // "someone else is waiting". gnt_q is zero when idle, so masking with it
   // leaves the full request vector in that case.
   always_comb begin
      search_base = (state_q == ST_GRANT) ? (gnt_idx_q + IDX_W'(1)) : ptr_q;
      search_mask = bus.req & ~gnt_q;
   end

   // Circular first-set search: base, base+1, ... wrapping modulo N_REQ.
   // The index arithmetic is IDX_W bits wide, so the wrap is implicit.
   always_comb begin
      logic [IDX_W-1:0] cand;
      cand      = '0;
      win_idx   = '0;
      win_found = 1'b0;
      for (int k = 0; k < N_REQ; k++) begin
         cand = search_base + IDX_W'(k);
         if (!win_found && search_mask[cand]) begin
            win_found = 1'b1;
            win_idx   = cand;
         end
      end
   end

   // State register plus registered grant outputs; reset acts at once.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         ptr_q       <= '0;
         hold_q      <= '0;
         gnt_q       <= '0;
         gnt_idx_q   <= '0;
         gnt_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         ptr_q       <= ptr_d;
         hold_q      <= hold_d;
         gnt_q       <= gnt_d;
         gnt_idx_q   <= gnt_idx_d;
         gnt_valid_q <= gnt_valid_d;
      end
   end

   // Next-state logic: decide between new grant, keep, or drop to idle.
   always_comb begin
      state_d     = state_q;
      ptr_d       = ptr_q;
      hold_d      = hold_q;
      gnt_d       = gnt_q;
      gnt_idx_d   = gnt_idx_q;
      gnt_valid_d = gnt_valid_q;
      grant_new   = 1'b0;
      go_idle     = 1'b0;

      unique case (state_q)
         ST_IDLE: begin
            // Nothing owned: grant the first request found from the pointer.
            if (bus.en && win_found) begin
               grant_new = 1'b1;
            end
         end
         ST_GRANT: begin
            if (!bus.en) begin
               // Enable removed: give up the resource regardless of requests.
               go_idle = 1'b1;
            end else if (!bus.req[gnt_idx_q]) begin
               // Owner released: hand over in the same edge if anyone waits,
               // so consecutive grants have no idle bubble.
               if (win_found) begin
                  grant_new = 1'b1;
               end else begin
                  go_idle = 1'b1;
               end
            end else if ((hold_q == HOLD_MAX) && win_found) begin
               // Owner used up its slot and others are waiting: preempt.
               grant_new = 1'b1;
            end else if (hold_q != HOLD_MAX) begin
               // Keep the owner; count up but never past the limit.
               hold_d = hold_q + HOLD_ONE;
            end
         end
         default: begin
            go_idle = 1'b1;
         end
      endcase

      if (grant_new) begin
         state_d     = ST_GRANT;
         gnt_d       = N_REQ'(1) << win_idx;
         gnt_idx_d   = win_idx;
         gnt_valid_d = 1'b1;
         hold_d      = HOLD_ONE;
         ptr_d       = win_idx + IDX_W'(1);
      end

      // gnt_idx is left alone so it keeps naming the last owner.
      if (go_idle) begin
         state_d     = ST_IDLE;
         gnt_d       = '0;
         gnt_valid_d = 1'b0;
         hold_d      = '0;
         ptr_d       = gnt_idx_q + IDX_W'(1);
      end
   end

   assign bus.gnt       = gnt_q;
   assign bus.gnt_idx   = gnt_idx_q;
   assign bus.gnt_valid = gnt_valid_q;

endmodule

// File: tb/tb_rr_arbiter_8.sv
// Testbench for rr_arbiter_8: directed scenarios plus a randomized run,
// all compared against a small behavioural model of the arbitration rules.
module tb_rr_arbiter_8;

   localparam int MAXH = 4;

   logic clk;
   logic rst_n;

   int tests_run    = 0;
   int tests_failed = 0;
   int cyc          = 0;

   // Behavioural model state: who owns the resource, for how long, and
   // where the next idle search starts.
   int m_valid;
   int m_idx;
   int m_ptr;
   int m_hold;

   rr_arbiter_8_if #(.N_REQ(8), .IDX_W(3)) bus ();

   rr_arbiter_8 #(.N_REQ(8), .IDX_W(3), .MAX_HOLD(MAXH)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // First requester found scanning base, base+1, ... modulo 8; -1 if none.
   function automatic int find_next(input int base, input logic [7:0] mask);
      for (int k = 0; k < 8; k++) begin
         if (mask[(base + k) % 8]) return (base + k) % 8;
      end
      return -1;
   endfunction

   function automatic logic [7:0] exp_gnt();
      logic [7:0] g;
      g = 8'h00;
      if (m_valid != 0) g[m_idx] = 1'b1;
      return g;
   endfunction

   task automatic model_reset();
      m_valid = 0;
      m_idx   = 0;
      m_ptr   = 0;
      m_hold  = 0;
   endtask

   task automatic model_grant(input int w);
      m_valid = 1;
      m_idx   = w;
      m_hold  = 1;
      m_ptr   = (w + 1) % 8;
   endtask

   // One clock edge of the arbitration rules, applied to the sampled inputs.
   task automatic model_edge(input logic en, input logic [7:0] req);
      logic [7:0] others;
      int w;
      if (m_valid == 0) begin
         if (en && req != 8'h00) model_grant(find_next(m_ptr, req));
      end else begin
         others = req;
         others[m_idx] = 1'b0;
         w = find_next(m_idx + 1, others);
         if (!en) begin
            m_valid = 0;
            m_ptr   = (m_idx + 1) % 8;
         end else if (!req[m_idx]) begin
            if (w >= 0) model_grant(w);
            else begin
               m_valid = 0;
               m_ptr   = (m_idx + 1) % 8;
            end
         end else if (m_hold == MAXH && w >= 0) begin
            model_grant(w);
         end else if (m_hold < MAXH) begin
            m_hold = m_hold + 1;
         end
      end
   endtask

   // Drive inputs on the falling edge, let the rising edge happen, update the
   // model and leave the caller 1 time unit after the edge to sample.
   task automatic cycle(input logic en, input logic [7:0] req);
      @(negedge clk);
      bus.en  = en;
      bus.req = req;
      @(posedge clk);
      model_edge(en, req);
      #1;
      cyc++;
      $display("[TB] cyc %0d en=%0b req=%02h -> gnt=%02h idx=%0d valid=%0b",
               cyc, en, req, bus.gnt, bus.gnt_idx, bus.gnt_valid);
   endtask

   // Quiet reset between scenarios.
   task automatic apply_reset();
      @(negedge clk);
      bus.en  = 1'b0;
      bus.req = 8'h00;
      rst_n   = 1'b0;
      model_reset();
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      bus.en  = 1'b1;
      bus.req = 8'hFF;
      rst_n   = 1'b0;
      model_reset();
      repeat (3) @(posedge clk);
      #1;
      tests_run++;
      if (bus.gnt !== 8'h00 || bus.gnt_valid !== 1'b0 || bus.gnt_idx !== 3'd0) begin
         tests_failed++;
         $display("FAIL reset_hold: gnt=%02h valid=%0b idx=%0d, need gnt=00 valid=0 idx=0",
                  bus.gnt, bus.gnt_valid, bus.gnt_idx);
      end
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      model_edge(1'b1, 8'hFF);
      #1;
      $display("[TB] reset release -> gnt=%02h idx=%0d valid=%0b",
               bus.gnt, bus.gnt_idx, bus.gnt_valid);
      tests_run++;
      if (bus.gnt !== 8'h01 || bus.gnt_idx !== 3'd0 || bus.gnt_valid !== 1'b1) begin
         tests_failed++;
         $display("FAIL reset_first_grant: gnt=%02h idx=%0d valid=%0b, need gnt=01 idx=0 valid=1",
                  bus.gnt, bus.gnt_idx, bus.gnt_valid);
      end
   endtask

   task automatic test_full_rotation();
      logic [2:0] want;
      apply_reset();
      for (int k = 0; k < 36; k++) begin
         cycle(1'b1, 8'hFF);
         want = 3'((k / MAXH) % 8);
         tests_run++;
         if (bus.gnt_idx !== want || bus.gnt !== (8'h01 << want) || bus.gnt_valid !== 1'b1) begin
            tests_failed++;
            $display("FAIL rotation[%0d]: idx=%0d gnt=%02h valid=%0b, need idx=%0d gnt=%02h valid=1",
                     k, bus.gnt_idx, bus.gnt, bus.gnt_valid, want, 8'h01 << want);
         end
      end
   endtask

   task automatic test_sole_requester();
      apply_reset();
      for (int k = 0; k < 10; k++) begin
         cycle(1'b1, 8'b0010_0000);
         tests_run++;
         if (bus.gnt_idx !== 3'd5 || bus.gnt !== 8'h20 || bus.gnt_valid !== 1'b1) begin
            tests_failed++;
            $display("FAIL sole_requester[%0d]: idx=%0d gnt=%02h valid=%0b, need idx=5 gnt=20 valid=1",
                     k, bus.gnt_idx, bus.gnt, bus.gnt_valid);
         end
      end
   endtask

   task automatic test_back_to_back();
      apply_reset();
      cycle(1'b1, 8'b0000_1000);
      tests_run++;
      if (bus.gnt_idx !== 3'd3 || bus.gnt_valid !== 1'b1) begin
         tests_failed++;
         $display("FAIL b2b_owner3: idx=%0d valid=%0b, need idx=3 valid=1", bus.gnt_idx, bus.gnt_valid);
      end
      cycle(1'b1, 8'b1000_0010);
      tests_run++;
      if (bus.gnt_idx !== 3'd7 || bus.gnt !== 8'h80 || bus.gnt_valid !== 1'b1) begin
         tests_failed++;
         $display("FAIL b2b_to7: idx=%0d gnt=%02h valid=%0b, need idx=7 gnt=80 valid=1",
                  bus.gnt_idx, bus.gnt, bus.gnt_valid);
      end
      cycle(1'b1, 8'b0000_0010);
      tests_run++;
      if (bus.gnt_idx !== 3'd1 || bus.gnt !== 8'h02 || bus.gnt_valid !== 1'b1) begin
         tests_failed++;
         $display("FAIL b2b_to1: idx=%0d gnt=%02h valid=%0b, need idx=1 gnt=02 valid=1",
                  bus.gnt_idx, bus.gnt, bus.gnt_valid);
      end
   endtask

   task automatic test_enable_drop();
      apply_reset();
      cycle(1'b1, 8'b0000_0100);
      cycle(1'b0, 8'b0000_0100);
      tests_run++;
      if (bus.gnt !== 8'h00 || bus.gnt_valid !== 1'b0 || bus.gnt_idx !== 3'd2) begin
         tests_failed++;
         $display("FAIL enable_drop: gnt=%02h valid=%0b idx=%0d, need gnt=00 valid=0 idx=2",
                  bus.gnt, bus.gnt_valid, bus.gnt_idx);
      end
      cycle(1'b1, 8'hFF);
      tests_run++;
      if (bus.gnt_idx !== 3'd3 || bus.gnt !== 8'h08 || bus.gnt_valid !== 1'b1) begin
         tests_failed++;
         $display("FAIL enable_resume: idx=%0d gnt=%02h valid=%0b, need idx=3 gnt=08 valid=1",
                  bus.gnt_idx, bus.gnt, bus.gnt_valid);
      end
   endtask

   task automatic test_async_reset();
      apply_reset();
      cycle(1'b1, 8'h10);
      cycle(1'b1, 8'h10);
      // Mid-cycle, away from both clock edges.
      #2;
      rst_n = 1'b0;
      model_reset();
      #1;
      $display("[TB] async reset mid-cycle -> gnt=%02h idx=%0d valid=%0b",
               bus.gnt, bus.gnt_idx, bus.gnt_valid);
      tests_run++;
      if (bus.gnt !== 8'h00 || bus.gnt_valid !== 1'b0 || bus.gnt_idx !== 3'd0) begin
         tests_failed++;
         $display("FAIL async_reset: gnt=%02h valid=%0b idx=%0d, need gnt=00 valid=0 idx=0",
                  bus.gnt, bus.gnt_valid, bus.gnt_idx);
      end
      @(negedge clk);
      bus.req = 8'hFF;
      rst_n   = 1'b1;
      cycle(1'b1, 8'hFF);
      tests_run++;
      if (bus.gnt_idx !== 3'd0 || bus.gnt !== 8'h01 || bus.gnt_valid !== 1'b1) begin
         tests_failed++;
         $display("FAIL async_reset_regrant: idx=%0d gnt=%02h valid=%0b, need idx=0 gnt=01 valid=1",
                  bus.gnt_idx, bus.gnt, bus.gnt_valid);
      end
   endtask

   task automatic test_random();
      logic [7:0] req;
      logic       en;
      apply_reset();
      req = 8'h00;
      for (int k = 0; k < 300; k++) begin
         // Each line flips with probability 1/4 so owners hold for a while.
         for (int b = 0; b < 8; b++) begin
            if ($urandom_range(0, 3) == 0) req[b] = ~req[b];
         end
         if (k >= 200 && k < 240) req = 8'hFF;
         en = ($urandom_range(0, 15) != 0);
         cycle(en, req);
         tests_run++;
         if (bus.gnt !== exp_gnt() || bus.gnt_valid !== (m_valid != 0) ||
             bus.gnt_idx !== 3'(m_idx)) begin
            tests_failed++;
            $display("FAIL random[%0d]: gnt=%02h idx=%0d valid=%0b, need gnt=%02h idx=%0d valid=%0d",
                     k, bus.gnt, bus.gnt_idx, bus.gnt_valid, exp_gnt(), m_idx, m_valid);
         end
      end
   endtask

   initial begin
      bus.en  = 1'b0;
      bus.req = 8'h00;
      rst_n   = 1'b0;
      model_reset();
      test_reset();
      test_full_rotation();
      test_sole_requester();
      test_back_to_back();
      test_enable_drop();
      test_async_reset();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

   // Time limit so the run always ends on its own.
   initial begin
      #200000;
      $display("FAIL timeout: simulation still running at %0t", $time);
      $fatal(1, "timeout");
   end

endmodule
